// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: counter control codes, FSM state type and debounce default.
package stopwatch_pkg;

  localparam int unsigned CTRL_W        = 2;
  localparam int unsigned DEBOUNCE_10MS = 500000;

  localparam logic [CTRL_W-1:0] CTRL_IDLE  = 2'b00;
  localparam logic [CTRL_W-1:0] CTRL_COUNT = 2'b01;
  localparam logic [CTRL_W-1:0] CTRL_PAUSE = 2'b10;

  typedef enum logic [CTRL_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability counter and falling-edge press detector for one raw button.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_10MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic stable_n,
  output logic press_evt
);

  localparam int unsigned      CNT_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mismatch;
  logic             update;

  assign mismatch = sync_q2 ^ stable_q;
  assign update   = mismatch && (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1  <= 1'b1;
      sync_q2  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync_q1 <= btn_n;
      sync_q2 <= sync_q1;
      if (!mismatch) begin
        cnt_q <= '0;
      end else if (update) begin
        stable_q <= sync_q2;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Event fires on the same edge the stable level drops, so the FSM moves in lock-step.
  assign stable_n  = stable_q;
  assign press_evt = update & ~sync_q2;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced start/pause and clear buttons driving the IDLE/COUNT/PAUSE FSM.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_10MS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_n,
  input  logic       btn_clear_n,
  output logic [1:0] cnt_ctrl,
  output logic       led_run,
  output logic       led_pause
);

  state_t state;
  logic   start_evt;
  logic   clear_evt;
  logic   start_stable_n;
  logic   clear_stable_n;
  logic   unused_stable;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_n     (btn_start_n),
    .stable_n  (start_stable_n),
    .press_evt (start_evt)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clear (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_n     (btn_clear_n),
    .stable_n  (clear_stable_n),
    .press_evt (clear_evt)
  );

  assign unused_stable = start_stable_n ^ clear_stable_n;

  // Clear outranks start in IDLE and PAUSE; a running watch ignores clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear_evt)      state <= ST_IDLE;
          else if (start_evt) state <= ST_COUNT;
        end
        ST_COUNT: begin
          if (start_evt) state <= ST_PAUSE;
        end
        ST_PAUSE: begin
          if (clear_evt)      state <= ST_IDLE;
          else if (start_evt) state <= ST_COUNT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode the state register alone; an illegal encoding reads as IDLE.
  always_comb begin
    cnt_ctrl  = CTRL_IDLE;
    led_run   = 1'b0;
    led_pause = 1'b0;
    case (state)
      ST_COUNT: begin
        cnt_ctrl = CTRL_COUNT;
        led_run  = 1'b1;
      end
      ST_PAUSE: begin
        cnt_ctrl  = CTRL_PAUSE;
        led_pause = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a short debounce window.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int unsigned DC = 4;

  logic       clk;
  logic       rst_n;
  logic       btn_start_n;
  logic       btn_clear_n;
  logic [1:0] cnt_ctrl;
  logic       led_run;
  logic       led_pause;

  int total;
  int bad;

  typedef struct {
    string      name;
    logic       start_n;
    logic       clear_n;
    int         cycles;
    logic [1:0] exp_ctrl;
    logic       exp_run;
    logic       exp_pause;
  } vec_t;

  vec_t vecs[$];

  stopwatch_ctrl #(.DEBOUNCE_CYC(DC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_start_n (btn_start_n),
    .btn_clear_n (btn_clear_n),
    .cnt_ctrl    (cnt_ctrl),
    .led_run     (led_run),
    .led_pause   (led_pause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic [1:0] ctrl, input logic run,
                          input logic pause);
    chk({name, ".cnt_ctrl"}, cnt_ctrl, ctrl);
    chk({name, ".led_run"}, {1'b0, led_run}, {1'b0, run});
    chk({name, ".led_pause"}, {1'b0, led_pause}, {1'b0, pause});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add(input string name, input logic s, input logic c, input int n,
                     input logic [1:0] ctrl, input logic run, input logic pause);
    vec_t v;
    v.name = name; v.start_n = s; v.clear_n = c; v.cycles = n;
    v.exp_ctrl = ctrl; v.exp_run = run; v.exp_pause = pause;
    vecs.push_back(v);
  endtask

  initial begin
    int  seen_evt;
    int  illegal;
    int  hold;
    total = 0;
    bad   = 0;

    // Pin levels applied at a negedge: stable flips on the 6th following edge.
    add("t1_edge5",        1'b0, 1'b1,   5, 2'b00, 1'b0, 1'b0);
    add("t1_edge6",        1'b0, 1'b1,   1, 2'b01, 1'b1, 1'b0);
    add("t1_hold100",      1'b0, 1'b1, 100, 2'b01, 1'b1, 1'b0);
    add("t2_release",      1'b1, 1'b1,  10, 2'b01, 1'b1, 1'b0);
    add("t2_press_e5",     1'b0, 1'b1,   5, 2'b01, 1'b1, 1'b0);
    add("t2_press_e6",     1'b0, 1'b1,   1, 2'b10, 1'b0, 1'b1);
    add("t2_release2",     1'b1, 1'b1,  10, 2'b10, 1'b0, 1'b1);
    add("t2_resume",       1'b0, 1'b1,   6, 2'b01, 1'b1, 1'b0);
    add("t2_release3",     1'b1, 1'b1,  10, 2'b01, 1'b1, 1'b0);
    add("t4_clr_in_count", 1'b1, 1'b0,   6, 2'b01, 1'b1, 1'b0);
    add("t4_clr_release",  1'b1, 1'b1,  10, 2'b01, 1'b1, 1'b0);
    add("t4_to_pause",     1'b0, 1'b1,   6, 2'b10, 1'b0, 1'b1);
    add("t4_rel_a",        1'b1, 1'b1,  10, 2'b10, 1'b0, 1'b1);
    add("t4_clr_in_pause", 1'b1, 1'b0,   6, 2'b00, 1'b0, 1'b0);
    add("t4_rel_b",        1'b1, 1'b1,  10, 2'b00, 1'b0, 1'b0);
    add("t4_to_count",     1'b0, 1'b1,   6, 2'b01, 1'b1, 1'b0);
    add("t4_rel_c",        1'b1, 1'b1,  10, 2'b01, 1'b1, 1'b0);
    add("t4_to_pause2",    1'b0, 1'b1,   6, 2'b10, 1'b0, 1'b1);
    add("t4_rel_d",        1'b1, 1'b1,  10, 2'b10, 1'b0, 1'b1);
    add("t4_both_pause_5", 1'b0, 1'b0,   5, 2'b10, 1'b0, 1'b1);
    add("t4_both_pause_6", 1'b0, 1'b0,   1, 2'b00, 1'b0, 1'b0);
    add("t4_rel_e",        1'b1, 1'b1,  10, 2'b00, 1'b0, 1'b0);
    add("t4_both_idle",    1'b0, 1'b0,   6, 2'b00, 1'b0, 1'b0);
    add("t4_rel_f",        1'b1, 1'b1,  10, 2'b00, 1'b0, 1'b0);
    add("t4_to_count2",    1'b0, 1'b1,   6, 2'b01, 1'b1, 1'b0);
    add("t4_rel_g",        1'b1, 1'b1,  10, 2'b01, 1'b1, 1'b0);
    add("t4_both_count",   1'b0, 1'b0,   6, 2'b10, 1'b0, 1'b1);
    add("t4_rel_h",        1'b1, 1'b1,  10, 2'b10, 1'b0, 1'b1);

    rst_n       = 1'b0;
    btn_start_n = 1'b1;
    btn_clear_n = 1'b1;
    cycles(3);
    #1 chk_outs("reset", 2'b00, 1'b0, 1'b0);
    chk("reset.stable_n", {1'b0, dut.u_start.stable_n}, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      btn_start_n = vecs[i].start_n;
      btn_clear_n = vecs[i].clear_n;
      cycles(vecs[i].cycles);
      chk_outs(vecs[i].name, vecs[i].exp_ctrl, vecs[i].exp_run, vecs[i].exp_pause);
      // Glitch bursts run from IDLE, right after the last IDLE-both vector settles.
      if (vecs[i].name == "t4_rel_f") begin
        seen_evt = 0;
        for (int p = 0; p < 5; p++) begin
          btn_start_n = 1'b0;
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (dut.u_start.press_evt) seen_evt++;
          end
          btn_start_n = 1'b1;
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (dut.u_start.press_evt) seen_evt++;
          end
        end
        cycles(6);
        chk("t3_glitch.cnt_ctrl", cnt_ctrl, 2'b00);
        chk("t3_glitch.press_evt_count", 2'(seen_evt > 3 ? 3 : seen_evt), 2'b00);
      end
    end

    // Reset mid-debounce while counting, start still held through reset release.
    btn_start_n = 1'b0;
    cycles(6);
    chk("t5_in_count", cnt_ctrl, 2'b01);
    btn_start_n = 1'b1;
    cycles(10);
    btn_start_n = 1'b0;
    cycles(3);
    #2 rst_n = 1'b0;
    #1 chk_outs("t5_async_rst", 2'b00, 1'b0, 1'b0);
    cycles(2);
    rst_n = 1'b1;
    cycles(5);
    chk("t5_held_e5", cnt_ctrl, 2'b00);
    cycles(1);
    chk_outs("t5_held_e6", 2'b01, 1'b1, 1'b0);
    btn_start_n = 1'b1;
    cycles(10);

    // Illegal state encoding recovers to IDLE.
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    cycles(2);
    force dut.state = state_t'(2'b11);
    #1 chk_outs("t6_forced", 2'b00, 1'b0, 1'b0);
    release dut.state;
    @(negedge clk);
    chk("t6_recover.cnt_ctrl", cnt_ctrl, 2'b00);
    chk("t6_recover.state", 2'(dut.state), 2'b00);

    // Random button activity: the illegal code must never appear on cnt_ctrl.
    illegal = 0;
    hold    = 0;
    for (int n = 0; n < 10000; n++) begin
      if (hold == 0) begin
        btn_start_n = 1'($urandom_range(0, 1));
        btn_clear_n = 1'($urandom_range(0, 1));
        hold        = int'($urandom_range(1, 12));
      end
      hold--;
      @(negedge clk);
      if (cnt_ctrl == 2'b11) illegal++;
      if (led_run && led_pause) illegal++;
    end
    chk("t6_random_no_illegal", 2'(illegal > 3 ? 3 : illegal), 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control stage of the stopwatch. It sits directly upstream of the time counter and drives that counter's 2-bit cnt_ctrl input.
- Takes two raw active-low push buttons (start/pause, clear) from the board pins.
- Synchronises and debounces each button, then detects press events.
- Runs a Moore FSM (IDLE/COUNT/PAUSE) whose state is output as cnt_ctrl. It also drives two status LEDs.
- System clock is 50 MHz.

Parameters:
DEBOUNCE_CYC, 500000, number of consecutive stable clk cycles before a button level is accepted (10 ms at 50 MHz); legal minimum 2
CNT_W, $clog2(DEBOUNCE_CYC), width of each debounce counter (derived; not overridden)

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
btn_start_n  input  1  raw start/pause button, asynchronous to clk, 0 = pressed
btn_clear_n  input  1  raw clear button, asynchronous to clk, 0 = pressed
cnt_ctrl  output  2  counter control: 2'b00 IDLE, 2'b01 COUNT, 2'b10 PAUSE; never 2'b11
led_run  output  1  1 while in COUNT
led_pause  output  1  1 while in PAUSE

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. All flops use posedge clk or negedge rst_n.
- Reset values:
  - sync flops = 1; debounced stable level = 1 (released); debounce counters = 0.
  - state = IDLE, so cnt_ctrl = 2'b00, led_run = 0, led_pause = 0.
- Synchroniser: each button passes through 2 flops; only the second flop output (sync) is used downstream.
- Debounce, per button:
  - If sync == stable, counter is cleared to 0.
  - If sync != stable and counter < DEBOUNCE_CYC-1, counter increments.
  - If sync != stable and counter == DEBOUNCE_CYC-1, stable takes the sync value and counter clears.
  - A mismatch shorter than DEBOUNCE_CYC cycles therefore never changes stable.
- Press event: a 1-cycle condition, true on the edge where stable goes 1->0. It is generated combinationally from the update condition, so the FSM changes state on the same edge that stable flips.
  - The release (0->1) produces no event.
  - Holding a button produces exactly one event.
- Latency: a pin held low from before edge 1 flips stable, and the state changes, on edge DEBOUNCE_CYC+2.
- FSM (Moore). cnt_ctrl, led_run and led_pause decode from the state register only (registered outputs, no glitches).
  - IDLE: start event -> COUNT. Clear event -> IDLE. Both on the same edge -> IDLE (clear wins).
  - COUNT: start event -> PAUSE. Clear event is ignored; a running watch cannot be cleared. Both on the same edge -> PAUSE.
  - PAUSE: start event -> COUNT. Clear event -> IDLE. Both on the same edge -> IDLE (clear wins).
  - No event: hold the current state.
- Illegal state encoding 2'b11 recovers to IDLE on the next edge.
- Reset mid-operation: state returns to IDLE immediately (asynchronously); debounce state is discarded.
- Button held through reset release: stable restarts at 1, so the held level is debounced and generates one press event. This is accepted as a real press.
- Both buttons are independent. Their events can coincide on one edge; the priorities above apply.

Decomposition:
- Shared package stopwatch_pkg holds:
  - Control codes CTRL_IDLE = 2'b00, CTRL_COUNT = 2'b01, CTRL_PAUSE = 2'b10. The same constants are used by the time counter.
  - Default debounce constant DEBOUNCE_10MS = 500000.
- One sub-module, btn_debounce, is instantiated twice.
  - Inputs: clk, rst_n, btn_n. Parameter: DEBOUNCE_CYC.
  - Outputs: stable_n and press_evt.
  - It contains the synchroniser, counter and event logic.
- The FSM lives in stopwatch_ctrl.

Test Plan:
All scenarios use DEBOUNCE_CYC=4.
1. Reset, then btn_start_n=0 held from before edge 1 -> cnt_ctrl 00 through edge 5, 01 from edge 6; led_run=1, led_pause=0. Holding for 100 more cycles causes no further change.
2. From COUNT: release start, wait 10 cycles, press start again -> cnt_ctrl 10 (PAUSE) after DEBOUNCE_CYC+2 edges, led_pause=1. A further start press -> 01.
3. Glitch: btn_start_n low for 3 cycles, then high, repeated 5 times -> cnt_ctrl stays 00, press_evt never asserted.
4. In COUNT press clear -> cnt_ctrl stays 01. In PAUSE press clear -> 00. Both buttons pressed on the same cycle while in PAUSE -> 00.
5. In COUNT, assert rst_n=0 mid-debounce of a start press -> cnt_ctrl 00 immediately (asynchronous). Release reset with start still held -> cnt_ctrl 01 after DEBOUNCE_CYC+2 edges.
6. Force the state register to 2'b11 -> cnt_ctrl 00 on the next edge; cnt_ctrl is never 11 at any sampled edge during a 10k-cycle random button run.
